// File: rtl/timer_array_if.sv
// Core data-bus port of the timer array: request strobe, address/data and one-cycle response.
interface timer_array_if;
  logic        timer_valid;
  logic        timer_instr;
  logic [31:0] timer_addr;
  logic [31:0] timer_wdata;
  logic [3:0]  timer_wstrb;
  logic [31:0] timer_rdata;
  logic        timer_ready;

  modport master (
    output timer_valid, timer_instr, timer_addr, timer_wdata, timer_wstrb,
    input  timer_rdata, timer_ready
  );
  modport slave (
    input  timer_valid, timer_instr, timer_addr, timer_wdata, timer_wstrb,
    output timer_rdata, timer_ready
  );
endinterface

// File: rtl/timer_array.sv
// Multi-channel machine timer: shared prescaled 64-bit mtime, NCH compare channels with level irqs.
// Define TIMER_SNAPSHOT_EN to latch mtime[63:32] on an mtime-lo read for tear-free lo-then-hi reads.
module timer_array #(
  parameter int unsigned           NCH        = 4,
  parameter int unsigned           PRESCALE_W = 16,
  parameter logic [PRESCALE_W-1:0] DIV_RESET  = '0,
  parameter logic [63:0]           CMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic           clk,
  input  logic           rst,
  timer_array_if.slave   bus,
  output logic [NCH-1:0] timer_irpt
);

  logic                  ready_q;
  logic [31:0]           rdata_q, rdata_d;
  logic [63:0]           mtime_q, mtime_d;
  logic [63:0]           cmp_q [NCH];
  logic [63:0]           cmp_d [NCH];
  logic [PRESCALE_W-1:0] cnt_q, cnt_d, div_q, div_d;
  logic                  en_q, en_d;
  logic [NCH-1:0]        irpt_q, irpt_d;
  logic                  req, wr, rd, tick, sel_mtime_lo;
  logic [11:0]           chan;
  logic [31:0]           ctrl_rd, ctrl_wr, rd_word, mtime_hi_rd;
  logic                  unused_bits;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return res;
  endfunction

  // A held valid is not re-accepted while its response is on the bus.
  assign req          = bus.timer_valid & ~ready_q;
  assign wr           = req & (|bus.timer_wstrb);
  assign rd           = req & ~(|bus.timer_wstrb);
  assign chan         = bus.timer_addr[14:3];
  assign sel_mtime_lo = bus.timer_addr[15] & (bus.timer_addr[3:2] == 2'd0);
  assign tick         = en_q & (cnt_q == div_q);

  always_comb begin
    ctrl_rd                   = '0;
    ctrl_rd[0]                = en_q;
    ctrl_rd[16 +: PRESCALE_W] = div_q;
  end
  assign ctrl_wr = merge_bytes(ctrl_rd, bus.timer_wdata, bus.timer_wstrb);

`ifdef TIMER_SNAPSHOT_EN
  logic [31:0] shadow_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q <= '0;
    end else if (rd && sel_mtime_lo) begin
      shadow_q <= mtime_q[63:32];
    end
  end
  assign mtime_hi_rd = shadow_q;
`else
  assign mtime_hi_rd = mtime_q[63:32];
`endif

  always_comb begin
    rd_word = '0;
    if (!bus.timer_addr[15]) begin
      for (int i = 0; i < NCH; i++) begin
        if (chan == 12'(i)) rd_word = bus.timer_addr[2] ? cmp_q[i][63:32] : cmp_q[i][31:0];
      end
    end else begin
      case (bus.timer_addr[3:2])
        2'd0:    rd_word = mtime_q[31:0];
        2'd1:    rd_word = mtime_hi_rd;
        2'd2:    rd_word = ctrl_rd;
        default: rd_word = '0;
      endcase
    end
  end

  always_comb begin
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    cnt_d   = cnt_q;
    if (en_q) cnt_d = tick ? '0 : cnt_q + PRESCALE_W'(1);
    en_d    = en_q;
    div_d   = div_q;
    for (int i = 0; i < NCH; i++) cmp_d[i] = cmp_q[i];
    rdata_d = rd ? rd_word : rdata_q;
    // Bus writes to mtime override the tick increment of the same cycle.
    if (wr) begin
      if (!bus.timer_addr[15]) begin
        for (int i = 0; i < NCH; i++) begin
          if (chan == 12'(i)) begin
            if (bus.timer_addr[2]) begin
              cmp_d[i][63:32] = merge_bytes(cmp_q[i][63:32], bus.timer_wdata, bus.timer_wstrb);
            end else begin
              cmp_d[i][31:0] = merge_bytes(cmp_q[i][31:0], bus.timer_wdata, bus.timer_wstrb);
            end
          end
        end
      end else begin
        case (bus.timer_addr[3:2])
          2'd0: mtime_d = {mtime_q[63:32],
                           merge_bytes(mtime_q[31:0], bus.timer_wdata, bus.timer_wstrb)};
          2'd1: mtime_d = {merge_bytes(mtime_q[63:32], bus.timer_wdata, bus.timer_wstrb),
                           mtime_q[31:0]};
          2'd2: begin
            en_d  = ctrl_wr[0];
            div_d = ctrl_wr[16 +: PRESCALE_W];
            cnt_d = '0;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) irpt_d[i] = (mtime_q >= cmp_q[i]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      mtime_q <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b1;
      div_q   <= DIV_RESET;
      irpt_q  <= '0;
      for (int i = 0; i < NCH; i++) cmp_q[i] <= CMP_RESET;
    end else begin
      ready_q <= req;
      rdata_q <= rdata_d;
      mtime_q <= mtime_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      div_q   <= div_d;
      irpt_q  <= irpt_d;
      for (int i = 0; i < NCH; i++) cmp_q[i] <= cmp_d[i];
    end
  end

  assign bus.timer_rdata = rdata_q;
  assign bus.timer_ready = ready_q;
  assign timer_irpt      = irpt_q;

  assign unused_bits = ^{bus.timer_instr, bus.timer_addr[31:16], bus.timer_addr[1:0], ctrl_wr[15:1]};

endmodule

// File: tb/tb_timer_array.sv
// Bench for timer_array: directed scenarios then random bus traffic against a behavioural model.
module tb_timer_array;
  localparam int NCH = 4;
`ifdef TIMER_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif
  localparam logic [31:0] A_MLO = 32'h8000, A_MHI = 32'h8004, A_CTRL = 32'h8008, A_RSV = 32'h800C;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [NCH-1:0] irpt;
  int             checks = 0;
  int             errors = 0;

  timer_array_if bus ();

  timer_array #(.NCH(NCH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .timer_irpt (irpt)
  );

  always #5 clk = ~clk;

  // Reference state, advanced once per rising edge from the bus inputs seen at that edge.
  logic [63:0]    m_mtime;
  logic [63:0]    m_cmp [NCH];
  logic [15:0]    m_div, m_phase;
  bit             m_en, m_ready;
  logic [31:0]    m_rdata, m_shadow;
  logic [NCH-1:0] m_irpt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] apply_strb(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  task automatic model_reset();
    m_mtime = '0; m_div = '0; m_phase = '0; m_en = 1'b1; m_ready = 1'b0;
    m_rdata = '0; m_shadow = '0; m_irpt = '0;
    for (int i = 0; i < NCH; i++) m_cmp[i] = 64'hFFFF_FFFF_FFFF_FFFF;
  endtask

  task automatic model_edge();
    bit             req, wr, ticked;
    int             ch;
    logic [31:0]    a, word, ctrl;
    logic [63:0]    nxt;
    logic [NCH-1:0] irq;
    a = bus.timer_addr;
    for (int i = 0; i < NCH; i++) irq[i] = (m_mtime >= m_cmp[i]);
    req = bus.timer_valid && !m_ready;
    wr  = req && (bus.timer_wstrb != 4'd0);
    // One tick every div+1 enabled cycles, counted from the last CTRL write.
    ticked = 1'b0;
    if (m_en) begin
      if (m_phase == m_div) begin ticked = 1'b1; m_phase = '0; end
      else m_phase = m_phase + 16'd1;
    end
    nxt  = m_mtime + (ticked ? 64'd1 : 64'd0);
    ctrl = {m_div, 15'd0, m_en};
    ch   = int'(a[14:3]);
    word = '0;
    if (!a[15]) begin
      if (ch < NCH) word = a[2] ? m_cmp[ch][63:32] : m_cmp[ch][31:0];
    end else begin
      case (a[3:2])
        2'd0: word = m_mtime[31:0];
        2'd1: word = SNAP ? m_shadow : m_mtime[63:32];
        2'd2: word = ctrl;
        default: word = '0;
      endcase
    end
    if (req && !wr) begin
      m_rdata = word;
      if (SNAP && a[15] && a[3:2] == 2'd0) m_shadow = m_mtime[63:32];
    end
    if (wr) begin
      if (!a[15]) begin
        if (ch < NCH) begin
          if (a[2]) m_cmp[ch][63:32] = apply_strb(m_cmp[ch][63:32], bus.timer_wdata, bus.timer_wstrb);
          else      m_cmp[ch][31:0]  = apply_strb(m_cmp[ch][31:0], bus.timer_wdata, bus.timer_wstrb);
        end
      end else if (a[3:2] == 2'd0) begin
        nxt = {m_mtime[63:32], apply_strb(m_mtime[31:0], bus.timer_wdata, bus.timer_wstrb)};
      end else if (a[3:2] == 2'd1) begin
        nxt = {apply_strb(m_mtime[63:32], bus.timer_wdata, bus.timer_wstrb), m_mtime[31:0]};
      end else if (a[3:2] == 2'd2) begin
        ctrl    = apply_strb(ctrl, bus.timer_wdata, bus.timer_wstrb);
        m_en    = ctrl[0];
        m_div   = ctrl[31:16];
        m_phase = '0;
      end
    end
    m_mtime = nxt;
    m_irpt  = irq;
    m_ready = req;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("ready", 64'(bus.timer_ready), 64'(m_ready));
    chk("irpt", 64'(irpt), 64'(m_irpt));
    chk("rdata", 64'(bus.timer_rdata), 64'(m_rdata));
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.timer_valid = 1'b1;
    bus.timer_instr = 1'($urandom_range(0, 1));
    bus.timer_addr  = a;
    bus.timer_wdata = d;
    bus.timer_wstrb = s;
  endtask

  task automatic release_bus();
    bus.timer_valid = 1'b0;
    bus.timer_wstrb = 4'd0;
  endtask

  // Two edges: accept, then response cycle with valid dropped.
  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] r);
    drive(a, d, s);
    step();
    r = bus.timer_rdata;
    release_bus();
    step();
  endtask

  initial begin
    logic [31:0] r, r2;
    int          cnt;
    bus.timer_valid = 1'b0; bus.timer_instr = 1'b0; bus.timer_addr = '0;
    bus.timer_wdata = '0;   bus.timer_wstrb = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.timer_ready), 64'd0);
    chk("rst_irpt", 64'(irpt), 64'd0);
    chk("rst_rdata", 64'(bus.timer_rdata), 64'd0);
    rst = 1'b1;

    // 1: reset compare values and single-cycle response.
    drive(32'h0, 32'h0, 4'h0);
    step();
    chk("t1_ready_pulse", 64'(bus.timer_ready), 64'd1);
    chk("t1_cmp0_lo", 64'(bus.timer_rdata), 64'hFFFF_FFFF);
    release_bus();
    step();
    chk("t1_ready_drop", 64'(bus.timer_ready), 64'd0);
    xfer(32'h4, 32'h0, 4'h0, r);
    chk("t1_cmp0_hi", 64'(r), 64'hFFFF_FFFF);

    // 2: compare channel 1 at 10 with div=0.
    xfer(A_CTRL, 32'h0, 4'hF, r);
    xfer(A_MLO, 32'h0, 4'hF, r);
    xfer(A_MHI, 32'h0, 4'hF, r);
    xfer(32'h8, 32'd10, 4'hF, r);
    xfer(32'hC, 32'h0, 4'hF, r);
    xfer(A_CTRL, 32'h1, 4'hF, r);
    chk("t2_irpt_early", 64'(irpt), 64'd0);
    repeat (20) step();
    chk("t2_irpt_late", 64'(irpt), 64'b0010);

    // 3: div=3 gives one tick per 4 clocks; en=0 freezes mtime.
    xfer(A_CTRL, 32'h0003_0001, 4'hF, r);
    xfer(A_MLO, 32'h0, 4'h0, r);
    repeat (6) step();
    xfer(A_MLO, 32'h0, 4'h0, r2);
    chk("t3_div3_delta", 64'(r2 - r), 64'd2);
    xfer(A_CTRL, 32'h0003_0000, 4'hF, r);
    xfer(A_MLO, 32'h0, 4'h0, r);
    repeat (6) step();
    xfer(A_MLO, 32'h0, 4'h0, r2);
    chk("t3_frozen", 64'(r2), 64'(r));

    // 4: wrap through 2^64-1 and drop irpt for cmp=5.
    xfer(A_MLO, 32'hFFFF_FFFE, 4'hF, r);
    xfer(A_MHI, 32'hFFFF_FFFF, 4'hF, r);
    xfer(32'h10, 32'd5, 4'hF, r);
    xfer(32'h14, 32'h0, 4'hF, r);
    chk("t4_irpt_high", 64'(irpt), 64'b0110);
    xfer(A_CTRL, 32'h1, 4'hF, r);
    xfer(A_CTRL, 32'h0, 4'hF, r);
    xfer(A_MLO, 32'h0, 4'h0, r);
    chk("t4_wrap_lo", 64'(r), 64'd0);
    xfer(A_MHI, 32'h0, 4'h0, r);
    chk("t4_wrap_hi", 64'(r), 64'd0);
    chk("t4_irpt_drop", 64'(irpt), 64'd0);

    // 5: partial mtime write on a tick cycle, then out-of-range channel.
    xfer(A_MLO, 32'h1122_0000, 4'hF, r);
    xfer(A_MHI, 32'h0000_00AB, 4'hF, r);
    xfer(A_CTRL, 32'h1, 4'hF, r);
    xfer(A_MLO, 32'h0000_1234, 4'b0011, r);
    xfer(A_MLO, 32'h0, 4'h0, r);
    chk("t5_partial_lo", 64'(r), 64'h1122_1235);
    xfer(A_MHI, 32'h0, 4'h0, r);
    chk("t5_hi_kept", 64'(r), 64'hAB);
    drive(32'(NCH) << 3, 32'h0, 4'h0);
    step();
    chk("t5_oob_ready", 64'(bus.timer_ready), 64'd1);
    chk("t5_oob_rdata", 64'(bus.timer_rdata), 64'd0);
    release_bus();
    step();

    // 6: lo-then-hi across a carry, and a held valid.
    xfer(A_CTRL, 32'h0, 4'hF, r);
    xfer(A_MLO, 32'hFFFF_FFFF, 4'hF, r);
    xfer(A_MHI, 32'h0, 4'hF, r);
    xfer(A_CTRL, 32'h0003_0001, 4'hF, r);
    xfer(A_MLO, 32'h0, 4'h0, r);
    chk("t6_lo", 64'(r), 64'hFFFF_FFFF);
    repeat (2) step();
    xfer(A_MHI, 32'h0, 4'h0, r);
    chk("t6_hi", 64'(r), SNAP ? 64'd0 : 64'd1);
    cnt = 0;
    drive(A_CTRL, 32'h0, 4'h0);
    step(); cnt += int'(bus.timer_ready);
    step(); cnt += int'(bus.timer_ready);
    release_bus();
    step(); cnt += int'(bus.timer_ready);
    chk("t6_single_ready", 64'(cnt), 64'd1);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      int          sel, ch;
      logic [31:0] a, d;
      logic [3:0]  s;
      sel = $urandom_range(0, 9);
      ch  = $urandom_range(0, NCH);
      case (sel)
        0, 1, 2, 3, 4: a = (32'(ch) << 3) | (32'($urandom_range(0, 1)) << 2);
        5: a = A_MLO;
        6: a = A_MHI;
        7: a = A_CTRL;
        8: a = A_RSV;
        default: a = $urandom & 32'hFFFF_FFFF;
      endcase
      a[1:0] = 2'($urandom_range(0, 3));
      if (a == A_CTRL || (a & 32'h800C) == A_CTRL) begin
        d = {14'd0, 2'($urandom_range(0, 3)), 15'd0, 1'($urandom_range(0, 4) != 0)};
      end else if (a[2] && $urandom_range(0, 9) < 7) begin
        d = 32'h0;
      end else begin
        d = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 64)) : $urandom;
      end
      case ($urandom_range(0, 4))
        0, 1: s = 4'h0;
        2, 3: s = 4'hF;
        default: s = 4'($urandom_range(0, 15));
      endcase
      drive(a, d, s);
      step();
      if ($urandom_range(0, 3) == 0) step();
      release_bus();
      step();
      repeat ($urandom_range(0, 3)) step();
    end

    // Asynchronous reset mid-cycle clears outputs without a clock edge.
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_ready", 64'(bus.timer_ready), 64'd0);
    chk("arst_irpt", 64'(irpt), 64'd0);
    chk("arst_rdata", 64'(bus.timer_rdata), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
